// File: rtl/l1_port1_arbiter.sv
// Port-1 arbiter for the L1 cache_memory: per-channel snoop FIFOs, round-robin
// snoop arbitration, starvation-bounded controller access and tagged snoop responses.
module l1_port1_arbiter #(
    parameter int NUM_SNOOP_CH = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int INDEX_BITS   = 8,
    parameter int TAG_BITS     = 22,
    parameter int SBITS        = 4,
    parameter int CACHE_WIDTH  = 128,
    parameter int WAY_BITS     = 2,
    parameter int OFFSET_BITS  = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int COH_BITS     = SBITS / 2,
    parameter int STATUS_BITS  = SBITS - COH_BITS
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_SNOOP_CH-1:0]                snp_valid,
    output logic [NUM_SNOOP_CH-1:0]                snp_ready,
    input  logic [2*NUM_SNOOP_CH-1:0]              snp_op,
    input  logic [INDEX_BITS*NUM_SNOOP_CH-1:0]     snp_index,
    input  logic [TAG_BITS*NUM_SNOOP_CH-1:0]       snp_tag,
    input  logic [SBITS*NUM_SNOOP_CH-1:0]          snp_meta,
    input  logic [CACHE_WIDTH*NUM_SNOOP_CH-1:0]    snp_data,
    input  logic [WAY_BITS*NUM_SNOOP_CH-1:0]       snp_way,
    input  logic                                   ctrl_read1,
    input  logic                                   ctrl_write1,
    input  logic                                   ctrl_invalidate1,
    input  logic [INDEX_BITS-1:0]                  ctrl_index1,
    input  logic [TAG_BITS-1:0]                    ctrl_tag1,
    input  logic [SBITS-1:0]                       ctrl_meta1,
    input  logic [CACHE_WIDTH-1:0]                 ctrl_data1,
    input  logic [WAY_BITS-1:0]                    ctrl_way1,
    output logic                                   ctrl_stall,
    output logic                                   mem_read1,
    output logic                                   mem_write1,
    output logic                                   mem_invalidate1,
    output logic [INDEX_BITS-1:0]                  mem_index1,
    output logic [TAG_BITS-1:0]                    mem_tag1,
    output logic [SBITS-1:0]                       mem_meta1,
    output logic [CACHE_WIDTH-1:0]                 mem_data1,
    output logic [WAY_BITS-1:0]                    mem_way1,
    input  logic [CACHE_WIDTH-1:0]                 mem_data_out1,
    input  logic [WAY_BITS-1:0]                    mem_matched_way1,
    input  logic [COH_BITS-1:0]                    mem_coh_bits1,
    input  logic [STATUS_BITS-1:0]                 mem_status_bits1,
    input  logic                                   mem_hit1,
    output logic                                   snoop_read,
    output logic                                   snoop_modify,
    output logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-1:0] snoop_address,
    output logic                                   rsp_valid,
    output logic [((NUM_SNOOP_CH > 1) ? $clog2(NUM_SNOOP_CH) : 1)-1:0] rsp_ch,
    output logic [CACHE_WIDTH-1:0]                 rsp_data,
    output logic [WAY_BITS-1:0]                    rsp_matched_way,
    output logic [COH_BITS-1:0]                    rsp_coh_bits,
    output logic [STATUS_BITS-1:0]                 rsp_status_bits,
    output logic                                   rsp_hit,
    output logic                                   err_drop
);
    localparam int CH_BITS  = (NUM_SNOOP_CH > 1) ? $clog2(NUM_SNOOP_CH) : 1;
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int STV_BITS = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int ENT_BITS = 2 + INDEX_BITS + TAG_BITS + SBITS + CACHE_WIDTH + WAY_BITS;

    logic [ENT_BITS-1:0]    fifo_q   [NUM_SNOOP_CH][FIFO_DEPTH];
    logic [ENT_BITS-1:0]    fifo_d   [NUM_SNOOP_CH][FIFO_DEPTH];
    logic [PTR_BITS-1:0]    rd_ptr_q [NUM_SNOOP_CH];
    logic [PTR_BITS-1:0]    rd_ptr_d [NUM_SNOOP_CH];
    logic [PTR_BITS-1:0]    wr_ptr_q [NUM_SNOOP_CH];
    logic [PTR_BITS-1:0]    wr_ptr_d [NUM_SNOOP_CH];
    logic [CNT_BITS-1:0]    cnt_q    [NUM_SNOOP_CH];
    logic [CNT_BITS-1:0]    cnt_d    [NUM_SNOOP_CH];
    logic [CH_BITS-1:0]     rr_q, rr_d;
    logic [STV_BITS-1:0]    starve_q, starve_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [CH_BITS-1:0]     rsp_ch_q, rsp_ch_d;
    logic [CACHE_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WAY_BITS-1:0]    rsp_way_q, rsp_way_d;
    logic [COH_BITS-1:0]    rsp_coh_q, rsp_coh_d;
    logic [STATUS_BITS-1:0] rsp_status_q, rsp_status_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic                   err_drop_q, err_drop_d;

    logic                   ctrl_req, snp_found, grant_ctrl, grant_snp;
    logic [CH_BITS-1:0]     snp_sel;
    logic [1:0]             h_op;
    logic [INDEX_BITS-1:0]  h_index;
    logic [TAG_BITS-1:0]    h_tag;
    logic [SBITS-1:0]       h_meta;
    logic [CACHE_WIDTH-1:0] h_data;
    logic [WAY_BITS-1:0]    h_way;

    always_comb begin
        snp_ready = '0;
        for (int c = 0; c < NUM_SNOOP_CH; c++)
            snp_ready[c] = (cnt_q[c] != CNT_BITS'(FIFO_DEPTH));
    end

    always_comb begin
        int cand;
        cand            = 0;
        ctrl_req        = ctrl_read1 | ctrl_write1 | ctrl_invalidate1;
        snp_found       = 1'b0;
        snp_sel         = '0;
        // Search starts just after the last granted channel.
        for (int k = 1; k <= NUM_SNOOP_CH; k++) begin
            cand = (int'(rr_q) + k) % NUM_SNOOP_CH;
            if (!snp_found && cnt_q[CH_BITS'(cand)] != '0) begin
                snp_found = 1'b1;
                snp_sel   = CH_BITS'(cand);
            end
        end
        grant_ctrl = ctrl_req && ((starve_q == STV_BITS'(STARVE_LIMIT)) || !snp_found);
        grant_snp  = snp_found && !grant_ctrl;
        {h_op, h_index, h_tag, h_meta, h_data, h_way} = fifo_q[snp_sel][rd_ptr_q[snp_sel]];

        mem_read1       = 1'b0;
        mem_write1      = 1'b0;
        mem_invalidate1 = 1'b0;
        mem_index1      = '0;
        mem_tag1        = '0;
        mem_meta1       = '0;
        mem_data1       = '0;
        mem_way1        = '0;
        snoop_read      = 1'b0;
        snoop_modify    = 1'b0;
        snoop_address   = '0;
        if (grant_ctrl) begin
            mem_read1       = ctrl_read1;
            mem_write1      = ctrl_write1;
            mem_invalidate1 = ctrl_invalidate1;
            mem_index1      = ctrl_index1;
            mem_tag1        = ctrl_tag1;
            mem_meta1       = ctrl_meta1;
            mem_data1       = ctrl_data1;
            mem_way1        = ctrl_way1;
        end else if (grant_snp && h_op != 2'b11) begin
            mem_read1       = (h_op == 2'b00);
            mem_write1      = (h_op == 2'b01);
            mem_invalidate1 = (h_op == 2'b10);
            mem_index1      = h_index;
            mem_tag1        = h_tag;
            mem_meta1       = h_meta;
            mem_data1       = h_data;
            mem_way1        = h_way;
            snoop_read      = (h_op == 2'b00);
            snoop_modify    = (h_op != 2'b00);
            snoop_address   = {h_tag, h_index, {OFFSET_BITS{1'b0}}};
        end
        ctrl_stall = ctrl_req && !grant_ctrl;

        rr_d         = grant_snp ? snp_sel : rr_q;
        starve_d     = (ctrl_req && !grant_ctrl) ? starve_q + STV_BITS'(1) : '0;
        rsp_valid_d  = grant_snp && (h_op != 2'b11);
        err_drop_d   = grant_snp && (h_op == 2'b11);
        rsp_ch_d     = rsp_ch_q;
        rsp_data_d   = rsp_data_q;
        rsp_way_d    = rsp_way_q;
        rsp_coh_d    = rsp_coh_q;
        rsp_status_d = rsp_status_q;
        rsp_hit_d    = rsp_hit_q;
        if (rsp_valid_d) begin
            rsp_ch_d     = snp_sel;
            rsp_data_d   = mem_data_out1;
            rsp_way_d    = mem_matched_way1;
            rsp_coh_d    = mem_coh_bits1;
            rsp_status_d = mem_status_bits1;
            rsp_hit_d    = mem_hit1;
        end
    end

    always_comb begin
        logic push, pop;
        push     = 1'b0;
        pop      = 1'b0;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int c = 0; c < NUM_SNOOP_CH; c++) begin
            push = snp_valid[c] && snp_ready[c];
            pop  = grant_snp && (snp_sel == CH_BITS'(c));
            if (push) begin
                fifo_d[c][wr_ptr_q[c]] = {snp_op[2*c +: 2],
                                          snp_index[INDEX_BITS*c +: INDEX_BITS],
                                          snp_tag[TAG_BITS*c +: TAG_BITS],
                                          snp_meta[SBITS*c +: SBITS],
                                          snp_data[CACHE_WIDTH*c +: CACHE_WIDTH],
                                          snp_way[WAY_BITS*c +: WAY_BITS]};
                wr_ptr_d[c] = wr_ptr_q[c] + PTR_BITS'(1);
            end
            if (pop)
                rd_ptr_d[c] = rd_ptr_q[c] + PTR_BITS'(1);
            if (push && !pop)
                cnt_d[c] = cnt_q[c] + CNT_BITS'(1);
            else if (pop && !push)
                cnt_d[c] = cnt_q[c] - CNT_BITS'(1);
        end
    end

    // Entry storage needs no reset: occupancy is governed by the counters alone.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
        if (reset) begin
            for (int c = 0; c < NUM_SNOOP_CH; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            rr_q         <= CH_BITS'(NUM_SNOOP_CH - 1);
            starve_q     <= '0;
            rsp_valid_q  <= 1'b0;
            err_drop_q   <= 1'b0;
            rsp_ch_q     <= '0;
            rsp_data_q   <= '0;
            rsp_way_q    <= '0;
            rsp_coh_q    <= '0;
            rsp_status_q <= '0;
            rsp_hit_q    <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            starve_q     <= starve_d;
            rsp_valid_q  <= rsp_valid_d;
            err_drop_q   <= err_drop_d;
            rsp_ch_q     <= rsp_ch_d;
            rsp_data_q   <= rsp_data_d;
            rsp_way_q    <= rsp_way_d;
            rsp_coh_q    <= rsp_coh_d;
            rsp_status_q <= rsp_status_d;
            rsp_hit_q    <= rsp_hit_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_ch          = rsp_ch_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_matched_way = rsp_way_q;
    assign rsp_coh_bits    = rsp_coh_q;
    assign rsp_status_bits = rsp_status_q;
    assign rsp_hit         = rsp_hit_q;
    assign err_drop        = err_drop_q;

endmodule

// File: tb/tb_l1_port1_arbiter.sv
// Directed bench for l1_port1_arbiter: a scoreboard of expected snoop responses per
// channel, popped by a monitor on rsp_valid, plus per-cycle checks of the memory port.
module tb_l1_port1_arbiter;
    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   snp_valid, snp_ready;
    logic [3:0]   snp_op;
    logic [15:0]  snp_index;
    logic [43:0]  snp_tag;
    logic [7:0]   snp_meta;
    logic [255:0] snp_data;
    logic [3:0]   snp_way;
    logic         ctrl_read1, ctrl_write1, ctrl_invalidate1;
    logic [7:0]   ctrl_index1;
    logic [21:0]  ctrl_tag1;
    logic [3:0]   ctrl_meta1;
    logic [127:0] ctrl_data1;
    logic [1:0]   ctrl_way1;
    logic         ctrl_stall;
    logic         mem_read1, mem_write1, mem_invalidate1;
    logic [7:0]   mem_index1;
    logic [21:0]  mem_tag1;
    logic [3:0]   mem_meta1;
    logic [127:0] mem_data1;
    logic [1:0]   mem_way1;
    logic [127:0] mem_data_out1;
    logic [1:0]   mem_matched_way1, mem_coh_bits1, mem_status_bits1;
    logic         mem_hit1;
    logic         snoop_read, snoop_modify;
    logic [31:0]  snoop_address;
    logic         rsp_valid;
    logic [0:0]   rsp_ch;
    logic [127:0] rsp_data;
    logic [1:0]   rsp_matched_way, rsp_coh_bits, rsp_status_bits;
    logic         rsp_hit, err_drop;

    always #5 clock = ~clock;

    l1_port1_arbiter dut (
        .clock(clock), .reset(reset),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op),
        .snp_index(snp_index), .snp_tag(snp_tag), .snp_meta(snp_meta),
        .snp_data(snp_data), .snp_way(snp_way),
        .ctrl_read1(ctrl_read1), .ctrl_write1(ctrl_write1), .ctrl_invalidate1(ctrl_invalidate1),
        .ctrl_index1(ctrl_index1), .ctrl_tag1(ctrl_tag1), .ctrl_meta1(ctrl_meta1),
        .ctrl_data1(ctrl_data1), .ctrl_way1(ctrl_way1), .ctrl_stall(ctrl_stall),
        .mem_read1(mem_read1), .mem_write1(mem_write1), .mem_invalidate1(mem_invalidate1),
        .mem_index1(mem_index1), .mem_tag1(mem_tag1), .mem_meta1(mem_meta1),
        .mem_data1(mem_data1), .mem_way1(mem_way1),
        .mem_data_out1(mem_data_out1), .mem_matched_way1(mem_matched_way1),
        .mem_coh_bits1(mem_coh_bits1), .mem_status_bits1(mem_status_bits1), .mem_hit1(mem_hit1),
        .snoop_read(snoop_read), .snoop_modify(snoop_modify), .snoop_address(snoop_address),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_data(rsp_data),
        .rsp_matched_way(rsp_matched_way), .rsp_coh_bits(rsp_coh_bits),
        .rsp_status_bits(rsp_status_bits), .rsp_hit(rsp_hit), .err_drop(err_drop)
    );

    // Memory stand-in: results are a fixed function of the operands presented.
    assign mem_data_out1    = mem_data1 ^ {mem_tag1, mem_index1, mem_way1, 96'h0};
    assign mem_matched_way1 = ~mem_way1;
    assign mem_coh_bits1    = mem_meta1[1:0];
    assign mem_status_bits1 = mem_meta1[3:2];
    assign mem_hit1         = mem_index1[0];

    typedef struct {
        logic [127:0] data;
        logic [1:0]   mway;
        logic [1:0]   coh;
        logic [1:0]   status;
        logic         hit;
    } rsp_exp_t;

    rsp_exp_t exp_q0[$];
    rsp_exp_t exp_q1[$];
    int       rsp_log[$];
    int       n_checks = 0;
    int       n_pass = 0;
    bit       mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    always @(negedge clock) begin
        rsp_exp_t e;
        if (mon_en && rsp_valid) begin
            if ((rsp_ch == 1'b0 && exp_q0.size() == 0) || (rsp_ch == 1'b1 && exp_q1.size() == 0)) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got rsp on ch %0d expected none", rsp_ch);
            end else begin
                if (rsp_ch == 1'b0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_way", 128'(rsp_matched_way), 128'(e.mway));
                chk("rsp_coh", 128'(rsp_coh_bits), 128'(e.coh));
                chk("rsp_status", 128'(rsp_status_bits), 128'(e.status));
                chk("rsp_hit", 128'(rsp_hit), 128'(e.hit));
                rsp_log.push_back(int'(rsp_ch));
            end
        end
    end

    function automatic logic [4:0] strobes();
        return {mem_read1, mem_write1, mem_invalidate1, snoop_read, snoop_modify};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_snp();
        snp_valid = '0; snp_op = '0; snp_index = '0; snp_tag = '0;
        snp_meta = '0; snp_data = '0; snp_way = '0;
    endtask

    task automatic clr_ctrl();
        ctrl_read1 = 0; ctrl_write1 = 0; ctrl_invalidate1 = 0;
        ctrl_index1 = '0; ctrl_tag1 = '0; ctrl_meta1 = '0; ctrl_data1 = '0; ctrl_way1 = '0;
    endtask

    task automatic set_snp(input int ch, input logic [1:0] op, input logic [7:0] idx,
                           input logic [21:0] tag, input logic [1:0] way);
        snp_valid[ch]          = 1'b1;
        snp_op[ch*2 +: 2]      = op;
        snp_index[ch*8 +: 8]   = idx;
        snp_tag[ch*22 +: 22]   = tag;
        snp_way[ch*2 +: 2]     = way;
        snp_meta[ch*4 +: 4]    = idx[3:0] ^ tag[3:0];
        snp_data[ch*128 +: 128] = {4{tag[7:0], idx, 16'hC0DE}};
    endtask

    task automatic push_exp(input int ch);
        rsp_exp_t e;
        if (snp_op[ch*2 +: 2] == 2'b11) return;
        e.data   = snp_data[ch*128 +: 128] ^ {snp_tag[ch*22 +: 22], snp_index[ch*8 +: 8], snp_way[ch*2 +: 2], 96'h0};
        e.mway   = ~snp_way[ch*2 +: 2];
        e.coh    = snp_meta[ch*4 +: 2];
        e.status = snp_meta[ch*4+2 +: 2];
        e.hit    = snp_index[ch*8];
        if (ch == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    task automatic commit(input bit track, output int n_acc);
        n_acc = 0;
        #1;
        for (int ch = 0; ch < 2; ch++) begin
            if (snp_valid[ch] && snp_ready[ch]) begin
                n_acc++;
                if (track) push_exp(ch);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_snp();
        clr_ctrl();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && i < budget) begin
            step();
            i++;
        end
        step();
        step();
        chk("drain_q0", 128'(exp_q0.size()), 128'(0));
        chk("drain_q1", 128'(exp_q1.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc_total, first_block;
        reset = 1'b1;
        clr_snp();
        clr_ctrl();
        step();
        step();
        chk("reset_ready", 128'(snp_ready), 128'(2'b11));
        chk("reset_strobes", 128'(strobes()), 128'(0));
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_stall", 128'(ctrl_stall), 128'(0));
        mon_en = 1'b1;
        reset = 1'b0;

        // Single ch0 read: issue at t+1, response at t+2.
        do_reset();
        set_snp(0, 2'b00, 8'h12, 22'h3, 2'b01);
        commit(1, acc);
        step();
        clr_snp();
        commit(1, acc);
        chk("t2_strobes", 128'(strobes()), 128'(5'b10010));
        chk("t2_index", 128'(mem_index1), 128'(8'h12));
        chk("t2_tag", 128'(mem_tag1), 128'(22'h3));
        chk("t2_addr", 128'(snoop_address), 128'({22'h3, 8'h12, 2'b00}));
        step();
        chk("t2_rsp_valid", 128'(rsp_valid), 128'(1));
        chk("t2_rsp_ch", 128'(rsp_ch), 128'(0));
        chk("t2_rsp_hit", 128'(rsp_hit), 128'(0));
        drain(20);

        // Two entries per channel pushed together: round-robin alternates.
        do_reset();
        rsp_log.delete();
        set_snp(0, 2'b00, 8'h21, 22'h100, 2'b00);
        set_snp(1, 2'b01, 8'h31, 22'h200, 2'b01);
        commit(1, acc);
        step();
        set_snp(0, 2'b10, 8'h22, 22'h101, 2'b10);
        set_snp(1, 2'b00, 8'h33, 22'h201, 2'b11);
        commit(1, acc);
        chk("t3_c1_strobes", 128'(strobes()), 128'(5'b10010));
        chk("t3_c1_index", 128'(mem_index1), 128'(8'h21));
        step();
        clr_snp();
        commit(1, acc);
        chk("t3_c2_strobes", 128'(strobes()), 128'(5'b01001));
        chk("t3_c2_index", 128'(mem_index1), 128'(8'h31));
        step();
        commit(1, acc);
        chk("t3_c3_strobes", 128'(strobes()), 128'(5'b00101));
        chk("t3_c3_index", 128'(mem_index1), 128'(8'h22));
        step();
        commit(1, acc);
        chk("t3_c4_strobes", 128'(strobes()), 128'(5'b10010));
        chk("t3_c4_index", 128'(mem_index1), 128'(8'h33));
        drain(20);
        chk("t3_rsp_count", 128'(rsp_log.size()), 128'(4));
        if (rsp_log.size() == 4) begin
            chk("t3_rsp_ch0", 128'(rsp_log[0]), 128'(0));
            chk("t3_rsp_ch1", 128'(rsp_log[1]), 128'(1));
            chk("t3_rsp_ch2", 128'(rsp_log[2]), 128'(0));
            chk("t3_rsp_ch3", 128'(rsp_log[3]), 128'(1));
        end

        // Both channels push every cycle for 12 cycles.
        do_reset();
        acc_total = 0;
        first_block = -1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            clr_snp();
            set_snp(0, 2'(c % 3), 8'(8'h40 + c), 22'(22'h1000 + c), 2'(c));
            set_snp(1, 2'((c + 1) % 3), 8'(8'h60 + c), 22'(22'h2000 + c), 2'(c + 1));
            commit(1, acc);
            acc_total += acc;
            if (first_block < 0 && snp_ready != 2'b11) first_block = c;
        end
        step();
        clr_snp();
        drain(60);
        chk("t4_accepted", 128'(acc_total), 128'(18));
        chk("t4_first_full", 128'(first_block), 128'(6));

        // Controller starved by a ch0 stream: forced grant after 4 denied cycles.
        do_reset();
        ctrl_index1 = 8'h5A;
        ctrl_tag1   = 22'h155;
        ctrl_meta1  = 4'h9;
        ctrl_data1  = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;
        ctrl_way1   = 2'b10;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            clr_snp();
            if (c <= 6) set_snp(0, 2'b00, 8'(8'h80 + c), 22'(22'h300 + c), 2'b00);
            ctrl_read1 = (c >= 1 && c <= 5);
            commit(1, acc);
            if (c >= 1 && c <= 4) begin
                chk("t5_stall", 128'(ctrl_stall), 128'(1));
                chk("t5_snoop_index", 128'(mem_index1), 128'(8'h80 + c - 1));
            end else if (c == 5) begin
                chk("t5_grant_stall", 128'(ctrl_stall), 128'(0));
                chk("t5_grant_strobes", 128'(strobes()), 128'(5'b10000));
                chk("t5_grant_index", 128'(mem_index1), 128'(8'h5A));
                chk("t5_grant_tag", 128'(mem_tag1), 128'(22'h155));
                chk("t5_grant_data", mem_data1, ctrl_data1);
            end else if (c == 6) begin
                chk("t6_resume_strobes", 128'(strobes()), 128'(5'b10010));
                chk("t6_resume_index", 128'(mem_index1), 128'(8'h84));
            end
        end
        step();
        clr_snp();
        clr_ctrl();
        drain(20);

        // Illegal op on ch1: dropped with err_drop, no memory op, no response.
        do_reset();
        set_snp(1, 2'b11, 8'h77, 22'h9, 2'b00);
        commit(1, acc);
        chk("t6_err_idle", 128'(err_drop), 128'(0));
        step();
        clr_snp();
        commit(1, acc);
        chk("t6_pop_strobes", 128'(strobes()), 128'(0));
        chk("t6_pop_index", 128'(mem_index1), 128'(0));
        chk("t6_pop_err", 128'(err_drop), 128'(0));
        step();
        commit(1, acc);
        chk("t6_err_pulse", 128'(err_drop), 128'(1));
        chk("t6_no_rsp", 128'(rsp_valid), 128'(0));
        step();
        commit(1, acc);
        chk("t6_err_clear", 128'(err_drop), 128'(0));

        // Reset with three entries queued: only the one already issued responds.
        step();
        set_snp(0, 2'b00, 8'h91, 22'h41, 2'b01);
        set_snp(1, 2'b00, 8'hA1, 22'h51, 2'b10);
        commit(0, acc);
        acc_total = acc;
        push_exp(0);
        step();
        set_snp(0, 2'b01, 8'h92, 22'h42, 2'b01);
        set_snp(1, 2'b10, 8'hA2, 22'h52, 2'b10);
        commit(0, acc);
        acc_total += acc;
        step();
        clr_snp();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("t7_accepted", 128'(acc_total), 128'(4));
        for (int c = 0; c < 4; c++) begin
            commit(0, acc);
            chk("t7_no_stale_strobes", 128'(strobes()), 128'(0));
            chk("t7_ready", 128'(snp_ready), 128'(2'b11));
            chk("t7_stall", 128'(ctrl_stall), 128'(0));
            step();
        end
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
